spi_mems_responder: RTL and testbench

//  SPI mode-0 slave that answers the 16-bit frames issued by the spi_control/SPI master path.

---
 rtl/spi_mems_responder.sv | 128 ++++++++++++
 tb/tb_spi_mems_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mems_responder.sv
// spi_mems_responder: SPI mode-0 slave serving a small register file plus a fixed WHO_AM_I ID,
// used as an in-FPGA MEMS sensor stand-in for loopback bring-up.
module spi_mems_responder #(
  parameter int         NUM_REGS      = 16,
  parameter logic [6:0] WHO_AM_I_ADDR = 7'h75,
  parameter logic [7:0] WHO_AM_I_VAL  = 8'h68,
  parameter logic [7:0] REG_RST_VAL   = 8'h00
) (
  input  logic       clk_150MHz_i,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       miso_oe,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG = 8'(NUM_REGS);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t      state_q;
  logic [2:0]  sclk_q, cs_q, mosi_q;
  logic [3:0]  bit_cnt_q;
  logic [6:0]  shift_q, addr_q;
  logic        rw_q;
  logic [7:0]  rd_shift_q;
  logic [7:0]  regs_q [NUM_REGS];
  logic        miso_q, oe_q, wr_strobe_q, frame_err_q, busy_q;
  logic [6:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise, wr_ok;
  logic [7:0]  byte_d, rd_val;
  // Index [1] is the synchronized value, [2] its one-cycle history for edge detection.
  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    sclk_fall = ~sclk_q[1] & sclk_q[2];
    cs_fall   = ~cs_q[1] & cs_q[2];
    cs_rise   = cs_q[1] & ~cs_q[2];
    byte_d    = {shift_q, mosi_q[1]};
    rd_val    = (byte_d[6:0] == WHO_AM_I_ADDR) ? WHO_AM_I_VAL :
                ({1'b0, byte_d[6:0]} < NREG) ? regs_q[byte_d[AW-1:0]] : 8'h00;
    wr_ok     = ~rw_q && ({1'b0, addr_q} < NREG) && (addr_q != WHO_AM_I_ADDR);
  end
  // CS chain resets asserted so a CS held low across reset never looks like a fresh frame start.
  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      sclk_q      <= '0;
      cs_q        <= '0;
      mosi_q      <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      rd_shift_q  <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST_VAL;
    end else begin
      sclk_q      <= {sclk_q[1:0], spi_sclk};
      cs_q        <= {cs_q[1:0], spi_cs_n};
      mosi_q      <= {mosi_q[1:0], spi_mosi};
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_rise) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        oe_q        <= 1'b0;
        miso_q      <= 1'b0;
        frame_err_q <= (state_q == CMD) || (state_q == DATA);
      end else begin
        case (state_q)
          IDLE: if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            oe_q      <= 1'b1;
            miso_q    <= 1'b0;
          end
          CMD: if (sclk_rise) begin
            shift_q   <= byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rw_q       <= byte_d[7];
              addr_q     <= byte_d[6:0];
              rd_shift_q <= rd_val;
              state_q    <= DATA;
            end
          end
          DATA: if (sclk_rise) begin
            shift_q   <= byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              state_q <= DONE;
              miso_q  <= 1'b0;
              if (wr_ok) begin
                regs_q[addr_q[AW-1:0]] <= byte_d;
                wr_strobe_q            <= 1'b1;
                wr_addr_q              <= addr_q;
                wr_data_q              <= byte_d;
              end
            end
          end else if (sclk_fall && rw_q) begin
            miso_q     <= rd_shift_q[7];
            rd_shift_q <= {rd_shift_q[6:0], 1'b0};
          end
          default: ;
        endcase
      end
    end
  end
  assign spi_miso  = miso_q;
  assign miso_oe   = oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_spi_mems_responder.sv
// tb_spi_mems_responder: randomized frame-level checks of spi_mems_responder against a register-file model.
`timescale 1ns/1ps
module tb_spi_mems_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_strobe, frame_err, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  int         errors = 0;
  int         checks = 0;
  int         strobe_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic [7:0] model [16];
  logic [15:0] rx;
  logic       busy_mid, oe_mid;
  int         ds, de;

  spi_mems_responder dut (
    .clk_150MHz_i(clk), .reset(reset), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso), .miso_oe(miso_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err), .busy(busy)
  );

  always #3.333 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (frame_err) err_cnt++;
    if (wr_strobe && frame_err) both_cnt++;
  end

  function automatic logic [7:0] model_read(input logic [6:0] a);
    return (a == 7'h75) ? 8'h68 : (a < 7'd16) ? model[a[3:0]] : 8'h00;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits);
    int h, s0, e0;
    h = $urandom_range(5, 9);
    s0 = strobe_cnt;
    e0 = err_cnt;
    rx = '0;
    cs_n = 1'b0;
    wait_cyc(h);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? w[15-i] : 1'($urandom);
      wait_cyc(h);
      if (i < 16) rx[15-i] = miso;
      sclk = 1'b1;
      wait_cyc(h);
      sclk = 1'b0;
    end
    wait_cyc(h);
    busy_mid = busy;
    oe_mid = miso_oe;
    cs_n = 1'b1;
    wait_cyc(12);
    ds = strobe_cnt - s0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    wait_cyc(5);
    checks++;
    if ({miso, miso_oe, wr_strobe, frame_err, busy, wr_addr, wr_data} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {miso, miso_oe, wr_strobe, frame_err, busy, wr_addr, wr_data});
    end
    reset = 1'b0;
    wait_cyc(8);
    checks++;
    if ({miso, miso_oe, busy, frame_err} !== 4'h0) begin
      errors++;
      $display("FAIL post_reset_idle: miso/oe/busy/err=%b expected 0000", {miso, miso_oe, busy, frame_err});
    end
  endtask

  task automatic test_who_am_i;
    spi_frame(16'hF500, 16);
    checks++;
    if (rx[7:0] !== 8'h68) begin errors++; $display("FAIL who_am_i: got %h expected 68", rx[7:0]); end
    checks++;
    if (rx[15:8] !== 8'h00) begin errors++; $display("FAIL cmd_miso_zero: got %h expected 00", rx[15:8]); end
    checks++;
    if (ds !== 0) begin errors++; $display("FAIL who_am_i_nostrobe: got %0d expected 0", ds); end
    checks++;
    if ({busy_mid, oe_mid} !== 2'b11) begin errors++; $display("FAIL busy_oe_mid: got %b expected 11", {busy_mid, oe_mid}); end
    checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin errors++; $display("FAIL busy_oe_after: got %b expected 000", {busy, miso_oe, miso}); end
  endtask

  task automatic test_write_read;
    spi_frame(16'h0355, 16);
    checks++;
    if (ds !== 1) begin errors++; $display("FAIL wr_strobe_count: got %0d expected 1", ds); end
    checks++;
    if ({last_addr, last_data} !== {7'h03, 8'h55}) begin
      errors++;
      $display("FAIL wr_addr_data: got %h/%h expected 03/55", last_addr, last_data);
    end
    model[3] = 8'h55;
    spi_frame(16'h8300, 16);
    checks++;
    if (rx[7:0] !== model_read(7'h03)) begin errors++; $display("FAIL read_reg3: got %h expected %h", rx[7:0], model_read(7'h03)); end
  endtask

  task automatic test_out_of_range;
    spi_frame(16'h2A11, 16);
    checks++;
    if (ds !== 0) begin errors++; $display("FAIL oor_nostrobe: got %0d expected 0", ds); end
    spi_frame(16'hAA00, 16);
    checks++;
    if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL oor_read: got %h expected 00", rx[7:0]); end
  endtask

  task automatic test_frame_err;
    spi_frame(16'h0377, 11);
    checks++;
    if (de !== 1) begin errors++; $display("FAIL short_frame_err: got %0d expected 1", de); end
    checks++;
    if (ds !== 0) begin errors++; $display("FAIL short_no_write: got %0d expected 0", ds); end
    spi_frame(16'h8300, 16);
    checks++;
    if (rx[7:0] !== model_read(7'h03)) begin errors++; $display("FAIL reg3_unchanged: got %h expected %h", rx[7:0], model_read(7'h03)); end
    checks++;
    if (de !== 0) begin errors++; $display("FAIL next_frame_noerr: got %0d expected 0", de); end
  endtask

  task automatic test_overlong;
    spi_frame(16'h0466, 20);
    checks++;
    if (ds !== 1 || {last_addr, last_data} !== {7'h04, 8'h66}) begin
      errors++;
      $display("FAIL overlong_write: count %0d %h/%h expected 1 04/66", ds, last_addr, last_data);
    end
    checks++;
    if (de !== 0) begin errors++; $display("FAIL overlong_noerr: got %0d expected 0", de); end
    model[4] = 8'h66;
    spi_frame(16'h8400, 16);
    checks++;
    if (rx[7:0] !== model_read(7'h04)) begin errors++; $display("FAIL read_reg4: got %h expected %h", rx[7:0], model_read(7'h04)); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    int s0, e0;
    w = 16'h0599;
    s0 = strobe_cnt;
    e0 = err_cnt;
    cs_n = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 16; i++) begin
      if (i == 12) begin
        reset = 1'b1;
        wait_cyc(2);
        checks++;
        if ({miso, miso_oe, wr_strobe, frame_err, busy, wr_addr, wr_data} !== 20'h0) begin
          errors++;
          $display("FAIL reset_mid_outputs: got %h expected 0", {miso, miso_oe, wr_strobe, frame_err, busy, wr_addr, wr_data});
        end
        reset = 1'b0;
      end
      mosi = w[15-i];
      wait_cyc(6);
      sclk = 1'b1;
      wait_cyc(6);
      sclk = 1'b0;
    end
    wait_cyc(6);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: busy=%b expected 0", busy); end
    cs_n = 1'b1;
    wait_cyc(12);
    checks++;
    if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: strobe %0d err %0d expected 0 0", strobe_cnt - s0, err_cnt - e0);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int a = 3; a <= 5; a++) begin
      spi_frame({1'b1, 7'(a), 8'h00}, 16);
      checks++;
      if (rx[7:0] !== model_read(7'(a))) begin errors++; $display("FAIL reset_readback_%0d: got %h expected 00", a, rx[7:0]); end
    end
  endtask

  task automatic test_random;
    logic [6:0] a;
    logic [7:0] d, exp_rd;
    logic       rw;
    int         n, k;
    bit         full, exp_wr;
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 3);
      a = (k < 2) ? 7'($urandom_range(0, 15)) : (k == 2) ? 7'h75 : 7'($urandom_range(16, 127));
      rw = 1'($urandom);
      d = 8'($urandom);
      k = $urandom_range(0, 5);
      n = (k == 0) ? $urandom_range(1, 15) : (k == 1) ? $urandom_range(17, 20) : 16;
      full = (n >= 16);
      exp_wr = full && !rw && a < 7'd16;
      exp_rd = model_read(a);
      spi_frame({rw, a, d}, n);
      checks++;
      if (de !== (full ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_frame_err: got %0d expected %0d", t, de, full ? 0 : 1); end
      checks++;
      if (ds !== (exp_wr ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_strobe: got %0d expected %0d", t, ds, exp_wr ? 1 : 0); end
      if (exp_wr) begin
        checks++;
        if ({last_addr, last_data} !== {a, d}) begin
          errors++;
          $display("FAIL rnd%0d_wr: got %h/%h expected %h/%h", t, last_addr, last_data, a, d);
        end
        model[a[3:0]] = d;
      end
      if (full) begin
        checks++;
        if (rx !== {8'h00, rw ? exp_rd : 8'h00}) begin
          errors++;
          $display("FAIL rnd%0d_miso: got %h expected %h", t, rx, {8'h00, rw ? exp_rd : 8'h00});
        end
      end
    end
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL strobe_err_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_who_am_i;
    test_write_read;
    test_out_of_range;
    test_frame_err;
    test_overlong;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
